// File: rtl/vga_font_wr_sched_pkg.sv
// ---------------------------------------------------------------------------
// vga_font_wr_sched_pkg
// Shared definitions for the VGA font write path. This package holds the font
// memory geometry constants, which the font memory instance also uses, and the
// write scheduler state encoding.
// ---------------------------------------------------------------------------
package vga_font_wr_sched_pkg;

  // 128 characters x 16 rows, 8 pixels per row.
  localparam int FONT_ADDR_WIDTH = 11;
  localparam int FONT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // accept requests, issue queued writes during blanking
    DRAIN = 2'd1,  // clear pending: flush queued writes first, no accepts
    CLEAR = 2'd2   // zero the whole font memory, one row per blank cycle
  } state_e;

endpackage : vga_font_wr_sched_pkg

// File: rtl/vga_sync_fifo.sv
// ---------------------------------------------------------------------------
// vga_sync_fifo
// Small single-clock FIFO with a first-word-fall-through head output.
// Ports:
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   push_i / wdata_i   write one entry (ignored when full)
//   pop_i              drop the head entry (ignored when empty)
//   full_o, empty_o    occupancy flags
//   count_o            number of stored entries
//   head_o             oldest entry, valid when empty_o is 0
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module vga_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; the pointers and count decide
  // which entries are meaningful, so resetting the data would only add logic.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule : vga_sync_fifo

// File: rtl/vga_font_wr_sched.sv
// ---------------------------------------------------------------------------
// vga_font_wr_sched
// Schedules writes to the VGA font memory so that they only land in cycles
// whose read data is unused (blanking). CPU glyph-row writes are buffered in
// a FIFO; a clear command zeroes every font row after the queued writes have
// gone out.
// Ports:
//   clk_i, rstn_i        25 MHz clock, asynchronous active-low reset
//   blank_i              lookahead: high now means the next edge is safe
//   req_valid_i/ready_o  CPU write request handshake
//   req_addr_i/data_i    glyph row address / pixels (MSB = leftmost)
//   clear_i              pulse: zero the whole font memory
//   clear_done_o         pulse, coincides with the final zero write
//   busy_o               work outstanding (FIFO non-empty or not IDLE)
//   pending_o            FIFO occupancy
//   font_addr_w_o, font_wr_en_o, font_din_o  registered font write port
// ---------------------------------------------------------------------------
module vga_font_wr_sched
  import vga_font_wr_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = FONT_ADDR_WIDTH,
  parameter int DATA_WIDTH = FONT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        blank_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [ADDR_WIDTH-1:0]       req_addr_i,
  input  logic [DATA_WIDTH-1:0]       req_data_i,
  input  logic                        clear_i,
  output logic                        clear_done_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] pending_o,
  output logic [ADDR_WIDTH-1:0]       font_addr_w_o,
  output logic                        font_wr_en_o,
  output logic [DATA_WIDTH-1:0]       font_din_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic                    done_q, done_d;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]           fifo_count, count_after;
  logic [ADDR_WIDTH-1:0]   head_addr;
  logic [DATA_WIDTH-1:0]   head_data;
  logic                    can_issue;

  vga_sync_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (fifo_push),
    .wdata_i ({req_addr_i, req_data_i}),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  ({head_addr, head_data})
  );

  // Requests are only taken in IDLE; DRAIN and CLEAR hold the CPU off.
  assign req_ready_o = (state_q == IDLE) && !fifo_full;
  assign fifo_push   = req_valid_i && req_ready_o;

  // A queued write goes out at the edge after blank_i is seen high.
  assign can_issue   = ((state_q == IDLE) || (state_q == DRAIN)) &&
                       !fifo_empty && blank_i;
  assign fifo_pop    = can_issue;

  // Occupancy as it will be after this edge; decides DRAIN vs CLEAR.
  assign count_after = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_en_d   = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;
    done_d    = 1'b0;

    if (can_issue) begin
      wr_en_d = 1'b1;
      addr_d  = head_addr;
      din_d   = head_data;
    end

    unique case (state_q)
      IDLE: begin
        if (clear_i) state_d = (count_after != '0) ? DRAIN : CLEAR;
      end
      DRAIN: begin
        if (count_after == '0) state_d = CLEAR;
      end
      CLEAR: begin
        if (blank_i) begin
          wr_en_d   = 1'b1;
          addr_d    = clr_cnt_q;
          din_d     = '0;
          clr_cnt_d = clr_cnt_q + 1'b1;  // wraps to 0 after the last row
          if (clr_cnt_q == '1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      done_q    <= done_d;
    end
  end

  assign font_wr_en_o  = wr_en_q;
  assign font_addr_w_o = addr_q;
  assign font_din_o    = din_q;
  assign clear_done_o  = done_q;
  assign pending_o     = fifo_count;
  assign busy_o        = !fifo_empty || (state_q != IDLE);

endmodule : vga_font_wr_sched
